// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter granting four requesters burst access to a single FIFO write port.
// Beats are handshaken combinationally; a one-cycle idle bubble separates consecutive grants.
module fifo_write_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                    w_clk,
    input  logic                    w_rst,
    input  logic [3:0]              req,
    input  logic [3:0]              last,
    input  logic [4*DATA_WIDTH-1:0] data,
    input  logic                    w_full,
    output logic [3:0]              ack,
    output logic                    w_en,
    output logic [DATA_WIDTH-1:0]   w_data,
    output logic [3:0]              grant
);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t     state;
    logic [1:0] owner;
    logic [1:0] last_owner;
    logic [3:0] beat_cnt;

    logic [1:0] pick;
    logic [1:0] cand;
    logic       pick_valid;
    logic       beat_ok;
    logic       burst_done;
    logic [3:0] beat_next;

    logic [DATA_WIDTH-1:0] slices [4];

    for (genvar i = 0; i < 4; i++) begin : g_slice
        assign slices[i] = data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Search downward so the candidate closest after last_owner is the one left standing.
    always_comb begin
        pick       = '0;
        cand       = '0;
        pick_valid = 1'b0;
        for (int k = 4; k >= 1; k--) begin
            cand = last_owner + 2'(k);
            if (req[cand]) begin
                pick       = cand;
                pick_valid = 1'b1;
            end
        end
    end

    always_comb begin
        beat_ok    = (state == BURST) && req[owner] && !w_full && !w_rst;
        beat_next  = beat_cnt + 4'd1;
        burst_done = last[owner] || (beat_next == 4'(MAX_BURST));
        w_en       = beat_ok;
        ack        = beat_ok ? (4'b0001 << owner) : 4'b0000;
        w_data     = (state == BURST) ? slices[owner] : '0;
    end

    // Burst ends on end-of-packet, on reaching MAX_BURST, or when the owner withdraws.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state      <= IDLE;
            grant      <= 4'b0000;
            owner      <= 2'd0;
            beat_cnt   <= 4'd0;
            last_owner <= 2'd3;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state    <= BURST;
                        owner    <= pick;
                        grant    <= 4'b0001 << pick;
                        beat_cnt <= 4'd0;
                    end
                end
                BURST: begin
                    if (!req[owner]) begin
                        state      <= IDLE;
                        grant      <= 4'b0000;
                        last_owner <= owner;
                    end else if (beat_ok) begin
                        beat_cnt <= beat_next;
                        if (burst_done) begin
                            state      <= IDLE;
                            grant      <= 4'b0000;
                            last_owner <= owner;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed scenario bench for fifo_write_arbiter; a second instance runs with MAX_BURST=1.
module tb_fifo_write_arbiter;

    localparam logic [31:0] DATA_VAL = 32'hD3C2B1A0;

    logic        w_clk = 1'b0;
    logic        w_rst;
    logic [3:0]  req;
    logic [3:0]  last;
    logic [31:0] data;
    logic        w_full;
    logic [3:0]  ack, grant, ack1, grant1;
    logic        w_en, w_en1;
    logic [7:0]  w_data, w_data1;

    int total = 0;
    int bad   = 0;

    fifo_write_arbiter #(.DATA_WIDTH(8), .MAX_BURST(4)) dut (
        .w_clk(w_clk), .w_rst(w_rst), .req(req), .last(last), .data(data),
        .w_full(w_full), .ack(ack), .w_en(w_en), .w_data(w_data), .grant(grant)
    );

    fifo_write_arbiter #(.DATA_WIDTH(8), .MAX_BURST(1)) dut1 (
        .w_clk(w_clk), .w_rst(w_rst), .req(req), .last(last), .data(data),
        .w_full(w_full), .ack(ack1), .w_en(w_en1), .w_data(w_data1), .grant(grant1)
    );

    always #5 w_clk = ~w_clk;

    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    task automatic test_reset();
        w_rst = 1'b1; req = 4'b1111; last = 4'b0000; w_full = 1'b0; data = DATA_VAL;
        tick();
        tick();
        @(negedge w_clk);
        total++;
        if (grant !== 4'b0000 || ack !== 4'b0000 || w_en !== 1'b0 || w_data !== 8'h00) begin
            bad++;
            $display("[TB] FAIL reset: grant=%b ack=%b w_en=%b w_data=%h, required 0000 0000 0 00",
                     grant, ack, w_en, w_data);
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic [1:0] g;
        logic [3:0] oh;
        w_rst = 1'b0;
        @(negedge w_clk);
        total++;
        if (grant !== 4'b0000 || w_en !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rr_first_idle: grant=%b w_en=%b, required 0000 0", grant, w_en);
        end
        tick();
        for (int n = 0; n < 5; n++) begin
            g  = 2'(n);
            oh = 4'b0001 << g;
            for (int b = 0; b < 4; b++) begin
                @(negedge w_clk);
                total++;
                if (grant !== oh || ack !== oh || w_en !== 1'b1 || w_data !== DATA_VAL[8*g +: 8]) begin
                    bad++;
                    $display("[TB] FAIL rr_beat g%0d b%0d: grant=%b ack=%b w_en=%b w_data=%h, required %b %b 1 %h",
                             n, b, grant, ack, w_en, w_data, oh, oh, DATA_VAL[8*g +: 8]);
                end
                tick();
            end
            if (n == 4) req = 4'b0000;
            @(negedge w_clk);
            total++;
            if (grant !== 4'b0000 || ack !== 4'b0000 || w_en !== 1'b0) begin
                bad++;
                $display("[TB] FAIL rr_bubble g%0d: grant=%b ack=%b w_en=%b, required 0000 0000 0",
                         n, grant, ack, w_en);
            end
            tick();
        end
    endtask

    task automatic test_last();
        req = 4'b0100;
        tick();
        @(negedge w_clk);
        total++;
        if (ack !== 4'b0100 || w_en !== 1'b1 || grant !== 4'b0100) begin
            bad++;
            $display("[TB] FAIL last_beat1: ack=%b w_en=%b grant=%b, required 0100 1 0100", ack, w_en, grant);
        end
        tick();
        last = 4'b0100;
        @(negedge w_clk);
        total++;
        if (ack !== 4'b0100 || w_en !== 1'b1) begin
            bad++;
            $display("[TB] FAIL last_beat2: ack=%b w_en=%b, required 0100 1", ack, w_en);
        end
        tick();
        last = 4'b0000;
        req  = 4'b0000;
        @(negedge w_clk);
        total++;
        if (grant !== 4'b0000 || ack !== 4'b0000 || w_en !== 1'b0) begin
            bad++;
            $display("[TB] FAIL last_exit: grant=%b ack=%b w_en=%b, required 0000 0000 0", grant, ack, w_en);
        end
        tick();
    endtask

    task automatic test_stall();
        req = 4'b0010;
        tick();
        @(negedge w_clk);
        total++;
        if (ack !== 4'b0010 || grant !== 4'b0010) begin
            bad++;
            $display("[TB] FAIL stall_beat1: ack=%b grant=%b, required 0010 0010", ack, grant);
        end
        tick();
        w_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge w_clk);
            total++;
            if (ack !== 4'b0000 || w_en !== 1'b0 || grant !== 4'b0010) begin
                bad++;
                $display("[TB] FAIL stall_hold c%0d: ack=%b w_en=%b grant=%b, required 0000 0 0010",
                         c, ack, w_en, grant);
            end
            tick();
        end
        w_full = 1'b0;
        for (int b = 0; b < 3; b++) begin
            @(negedge w_clk);
            total++;
            if (ack !== 4'b0010 || w_en !== 1'b1 || w_data !== 8'hB1) begin
                bad++;
                $display("[TB] FAIL stall_resume b%0d: ack=%b w_en=%b w_data=%h, required 0010 1 b1",
                         b, ack, w_en, w_data);
            end
            tick();
        end
        req = 4'b0000;
        @(negedge w_clk);
        total++;
        if (grant !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL stall_count_exit: grant=%b, required 0000", grant);
        end
        tick();
    endtask

    task automatic test_drop();
        req = 4'b1001;
        tick();
        @(negedge w_clk);
        total++;
        if (grant !== 4'b1000 || ack !== 4'b1000) begin
            bad++;
            $display("[TB] FAIL drop_beat1: grant=%b ack=%b, required 1000 1000", grant, ack);
        end
        tick();
        req = 4'b0001;
        @(negedge w_clk);
        total++;
        if (ack !== 4'b0000 || w_en !== 1'b0 || grant !== 4'b1000) begin
            bad++;
            $display("[TB] FAIL drop_noreq: ack=%b w_en=%b grant=%b, required 0000 0 1000", ack, w_en, grant);
        end
        tick();
        @(negedge w_clk);
        total++;
        if (grant !== 4'b0000 || ack !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL drop_bubble: grant=%b ack=%b, required 0000 0000", grant, ack);
        end
        tick();
        @(negedge w_clk);
        total++;
        if (grant !== 4'b0001 || ack !== 4'b0001 || w_data !== 8'hA0) begin
            bad++;
            $display("[TB] FAIL drop_next_grant: grant=%b ack=%b w_data=%h, required 0001 0001 a0",
                     grant, ack, w_data);
        end
        tick();
        req = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid_burst();
        req = 4'b0100;
        tick();
        tick();
        tick();
        w_rst = 1'b1;
        req   = 4'b1110;
        @(negedge w_clk);
        total++;
        if (ack !== 4'b0000 || w_en !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rst_mid_strobe: ack=%b w_en=%b, required 0000 0", ack, w_en);
        end
        tick();
        w_rst = 1'b0;
        req   = 4'b0110;
        @(negedge w_clk);
        total++;
        if (grant !== 4'b0000 || ack !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL rst_mid_grant: grant=%b ack=%b, required 0000 0000", grant, ack);
        end
        tick();
        @(negedge w_clk);
        total++;
        if (grant !== 4'b0010 || ack !== 4'b0010) begin
            bad++;
            $display("[TB] FAIL rst_mid_regrant: grant=%b ack=%b, required 0010 0010", grant, ack);
        end
        tick();
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_max_burst_one();
        logic [3:0] oh;
        w_rst = 1'b1;
        tick();
        w_rst = 1'b0;
        req   = 4'b1001;
        tick();
        for (int n = 0; n < 4; n++) begin
            oh = (n % 2 == 0) ? 4'b0001 : 4'b1000;
            @(negedge w_clk);
            total++;
            if (grant1 !== oh || ack1 !== oh || w_en1 !== 1'b1) begin
                bad++;
                $display("[TB] FAIL mb1_grant n%0d: grant=%b ack=%b w_en=%b, required %b %b 1",
                         n, grant1, ack1, w_en1, oh, oh);
            end
            tick();
            @(negedge w_clk);
            total++;
            if (grant1 !== 4'b0000 || ack1 !== 4'b0000) begin
                bad++;
                $display("[TB] FAIL mb1_bubble n%0d: grant=%b ack=%b, required 0000 0000", n, grant1, ack1);
            end
            tick();
        end
        req = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_last();
        test_stall();
        test_drop();
        test_reset_mid_burst();
        test_max_burst_one();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of each requester's write data and of w_data.
REQ-002 SHALL have parameter MAX_BURST, default 4, maximum beats per grant; legal range 1..15.
REQ-003 SHALL have port w_clk  input  1  write-domain clock; all logic on its rising edge.
REQ-004 SHALL have port w_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req  input  4  per-requester write request; bit i = requester i.
REQ-006 SHALL have port last  input  4  per-requester end-of-packet flag, qualified by req.
REQ-007 SHALL have port data  input  4*DATA_WIDTH  requester data; slice i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port w_full  input  1  FIFO full flag, already in the w_clk domain.
REQ-009 SHALL have port ack  output  4  one-hot beat-accepted strobe back to requesters.
REQ-010 SHALL have port w_en  output  1  FIFO write enable.
REQ-011 SHALL have port w_data  output  DATA_WIDTH  FIFO write data.
REQ-012 SHALL have port grant  output  4  one-hot registered current owner; 0 when idle.

Function
REQ-013 SHALL implement FSM with states IDLE and BURST, plus registers owner[1:0], last_owner[1:0], beat_cnt[3:0].
REQ-014 In IDLE with req != 0, SHALL select the first requester with req set, searching last_owner+1, +2, +3, +4 (mod 4), and enter BURST next cycle with grant = onehot(selected), owner = selected, beat_cnt = 0.
REQ-015 In IDLE with req == 0, SHALL remain in IDLE with grant = 0.
REQ-016 A beat SHALL be accepted in a cycle iff state == BURST, req[owner] = 1 and w_full = 0.
REQ-017 On an accepted beat, SHALL drive w_en = 1, ack = onehot(owner), w_data = data slice of owner, combinationally in that cycle (zero-latency handshake), and increment beat_cnt.
REQ-018 When no beat is accepted, w_en and ack SHALL be 0; w_data SHALL be the owner's slice in BURST and 0 in IDLE.
REQ-019 While in BURST with w_full = 1, SHALL stall without leaving BURST and without changing beat_cnt.
REQ-020 SHALL leave BURST for IDLE at the next edge when: an accepted beat has last[owner] = 1; or an accepted beat brings beat_cnt to MAX_BURST; or req[owner] = 0.
REQ-021 On leaving BURST, SHALL set last_owner = owner and grant = 0; a one-cycle IDLE arbitration bubble between grants is required.
REQ-022 Requests from non-owners SHALL be ignored during BURST; no preemption.
REQ-023 ack SHALL never assert for more than one requester, and never while w_full = 1.
REQ-024 beat_cnt SHALL NOT wrap; it saturates at MAX_BURST only as the exit condition.

Reset
REQ-025 With w_rst = 1 at a rising edge, SHALL set state IDLE, grant 0, owner 0, beat_cnt 0, last_owner 3 (requester 0 wins first).
REQ-026 During reset cycles w_en and ack SHALL be 0, regardless of req and w_full.
REQ-027 Reset asserted mid-BURST SHALL abort the burst at that edge, with no further ack to the interrupted requester.

Verification
REQ-028 Reset release, req=4'b1111, last=0, w_full=0 -> grants in order 0,1,2,3,0; each grant 4 consecutive acks, 1 idle cycle between.
REQ-029 req=4'b0100, last[2] asserted on 2nd beat -> exactly 2 ack[2] pulses, w_en=2 pulses, then grant=0.
REQ-030 Owner 1 mid-burst, w_full=1 for 3 cycles -> w_en=0, ack=0 for 3 cycles, grant stays 4'b0010, burst resumes with beat_cnt intact.
REQ-031 Owner 3 drops req after 1 beat while req[0]=1 -> IDLE for 1 cycle, then grant=4'b0001.
REQ-032 w_rst=1 during 3rd beat of owner 2 -> grant=0 next cycle; first grant after reset goes to lowest-index active requester from requester 0.
REQ-033 MAX_BURST=1, req=4'b1001 continuous -> grants alternate 0,3,0,3 with one ack each.
